// File: rtl/display_scan_ctrl.sv
// Multiplexed 6-digit 7-segment scan controller: latches a digit set from an
// external mux, then blanks and shows each digit in turn with registered outputs.
module display_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_digit,
  output logic [2:0] o_sel,
  output logic       o_latch,
  output logic [6:0] o_seg,
  output logic [5:0] o_dig_en,
  output logic       o_frame_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);
  localparam logic [2:0]    LAST_IDX   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_BLANK,
    S_SHOW
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [2:0]    sel_d;
  logic          latch_d;
  logic [5:0]    dig_en_d;
  logic          frame_done_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      4'd10:   seg = 7'h00;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d = S_LATCH;
          idx_d   = 3'd0;
        end
      end
      S_LATCH: begin
        state_d = S_BLANK;
        idx_d   = 3'd0;
        bcnt_d  = '0;
      end
      S_BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          dcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (dcnt_q == DWELL_LAST) begin
          if (idx_q != LAST_IDX) begin
            state_d = S_BLANK;
            idx_d   = idx_q + 3'd1;
            bcnt_d  = '0;
          end else begin
            // i_en only matters here and in IDLE, so a frame always completes.
            state_d = i_en ? S_LATCH : S_IDLE;
            idx_d   = 3'd0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    latch_d      = (state_d == S_LATCH);
    sel_d        = (state_d == S_BLANK || state_d == S_SHOW) ? idx_d : 3'd0;
    dig_en_d     = (state_d == S_SHOW) ? (6'b000001 << idx_d) : 6'b000000;
    frame_done_d = (state_d == S_SHOW) && (idx_d == LAST_IDX) && (dcnt_d == DWELL_LAST);
    seg_d        = seg_decode(i_digit);
  end

  // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      bcnt_q       <= '0;
      dcnt_q       <= '0;
      o_sel        <= 3'd0;
      o_latch      <= 1'b0;
      o_seg        <= 7'h00;
      o_dig_en     <= 6'b000000;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      dcnt_q       <= dcnt_d;
      o_sel        <= sel_d;
      o_latch      <= latch_d;
      o_seg        <= seg_d;
      o_dig_en     <= dig_en_d;
      o_frame_done <= frame_done_d;
    end
  end

endmodule
